// File: rtl/mac_result_unpack_acc.sv
// Unpacks a 16-bit packed product word (1x16, 2x8 or 4x4 lanes), accumulates
// each active lane over a configurable number of beats, then drains the lane
// results one at a time over a valid/ready output.
module mac_result_unpack_acc #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_signed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_mode;
  logic               r_signed;
  logic [LEN_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc [4];
  logic               r_ovf;
  logic [1:0]         r_lane;
  logic               r_done;

  logic [1:0]         w_last_lane;
  logic [3:0]         w_act;
  logic [3:0]         w_lovf;
  logic [ACC_W-1:0]   w_add [4];
  logic [ACC_W-1:0]   w_sum [4];
  logic               w_beat;
  logic               w_xfer;
  logic               w_last_xfer;

  // Pull one lane field out of the packed word and extend it to ACC_W.
  // Mode 3 falls into the default and behaves like mode 0.
  function automatic logic [ACC_W-1:0] lane_ext(
    input logic [15:0] raw,
    input logic [1:0]  mode,
    input logic        sgn,
    input logic [1:0]  lane
  );
    logic [7:0] b8;
    logic [3:0] b4;
    logic [ACC_W-1:0] v;
    b8 = lane[0] ? raw[15:8] : raw[7:0];
    case (lane)
      2'd0:    b4 = raw[3:0];
      2'd1:    b4 = raw[7:4];
      2'd2:    b4 = raw[11:8];
      default: b4 = raw[15:12];
    endcase
    case (mode)
      2'd1:    v = sgn ? ACC_W'($signed(b8)) : ACC_W'(b8);
      2'd2:    v = sgn ? ACC_W'($signed(b4)) : ACC_W'(b4);
      default: v = sgn ? ACC_W'($signed(raw)) : ACC_W'(raw);
    endcase
    return v;
  endfunction

  // Carry-out for unsigned lanes, two's-complement overflow for signed lanes.
  function automatic logic add_ovf(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic             sgn
  );
    logic [ACC_W:0] s;
    logic           o;
    s = {1'b0, a} + {1'b0, b};
    if (sgn) o = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    else     o = s[ACC_W];
    return o;
  endfunction

  // Index of the final active lane for the latched mode (1, 2 or 4 lanes).
  assign w_last_lane = (r_mode == 2'd1) ? 2'd1 :
                       (r_mode == 2'd2) ? 2'd3 : 2'd0;

  // Per-lane addend, wrapped sum and overflow for the current input word.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      w_act[l]  = (2'(l) <= w_last_lane);
      w_add[l]  = lane_ext(in_data, r_mode, r_signed, 2'(l));
      w_sum[l]  = r_acc[l] + w_add[l];
      w_lovf[l] = w_act[l] && add_ovf(r_acc[l], w_add[l], r_signed);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_xfer      = 1'b0;
    w_last_xfer = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_lane    = 2'd0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_ACC;
      end
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_beat = 1'b1;
          if (r_cnt == LEN_W'(1)) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_lane  = r_lane;
        out_last  = (r_lane == w_last_lane);
        out_data  = r_acc[r_lane];
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_lane == w_last_lane) begin
            w_last_xfer = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job configuration, beat counter, accumulators, overflow and drain lane.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mode   <= 2'd0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_lane   <= 2'd0;
      r_done   <= 1'b0;
      for (int l = 0; l < 4; l++) r_acc[l] <= '0;
    end else begin
      r_done <= w_last_xfer;
      if (r_state == S_IDLE && start) begin
        r_mode   <= cfg_mode;
        r_signed <= cfg_signed;
        r_cnt    <= cfg_len;
        r_ovf    <= 1'b0;
        r_lane   <= 2'd0;
        for (int l = 0; l < 4; l++) r_acc[l] <= '0;
      end else if (w_beat) begin
        r_cnt  <= r_cnt - LEN_W'(1);
        r_lane <= 2'd0;
        if (|w_lovf) r_ovf <= 1'b1;
        for (int l = 0; l < 4; l++) begin
          if (w_act[l]) r_acc[l] <= w_sum[l];
        end
      end else if (w_xfer) begin
        r_lane <= w_last_xfer ? 2'd0 : r_lane + 2'd1;
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_mac_result_unpack_acc.sv
// Directed bench for mac_result_unpack_acc: a 24-bit and a 16-bit accumulator
// instance share one stimulus stream.
module tb_mac_result_unpack_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_mode;
  logic        cfg_signed;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy, done, ovf;
  logic [23:0] out_data;
  logic [1:0]  out_lane;

  logic        in_ready16, out_valid16, out_last16, busy16, done16, ovf16;
  logic [15:0] out_data16;
  logic [1:0]  out_lane16;

  int n_chk  = 0;
  int n_fail = 0;

  mac_result_unpack_acc #(.ACC_W(24), .LEN_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_signed(cfg_signed), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .busy(busy), .done(done), .ovf(ovf)
  );

  mac_result_unpack_acc #(.ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
    .cfg_signed(cfg_signed), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(in_ready16), .in_data(in_data), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .out_lane(out_lane16),
    .out_last(out_last16), .busy(busy16), .done(done16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then scramble cfg_* so a late change would be visible.
  task automatic start_job(input logic [1:0] m, input logic s, input logic [7:0] len);
    start = 1'b1; cfg_mode = m; cfg_signed = s; cfg_len = len;
    step();
    start = 1'b0; cfg_mode = ~m; cfg_signed = ~s; cfg_len = len + 8'd3;
    chk("acc_in_ready", in_ready, 1'b1);
    chk("acc_busy", busy, 1'b1);
    chk("acc_out_valid", out_valid, 1'b0);
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    step();
    in_valid = 1'b0; in_data = 16'h0;
  endtask

  // Check the presented lane, then transfer it.
  task automatic take(input string tag, input logic [1:0] ln, input logic [23:0] d, input logic lst);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_lane"}, out_lane, ln);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, out_last, lst);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
    chk({tag, "_idle_data"}, out_data, 24'h0);
    step();
    chk({tag, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; cfg_mode = 2'd0; cfg_signed = 1'b0; cfg_len = 8'd0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    reset = 1'b1;

    // 1x16 signed, -256 + 256 with an idle cycle between beats
    start_job(2'd0, 1'b1, 8'd2);
    beat(16'hFF00);
    step();
    chk("m0_gap_ready", in_ready, 1'b1);
    chk("m0_gap_valid", out_valid, 1'b0);
    beat(16'h0100);
    chk("m0_ovf", ovf, 1'b0);
    take("m0_l0", 2'd0, 24'h000000, 1'b1);
    expect_done("m0");

    // 2x8 unsigned with a 3-cycle stall on lane 0
    start_job(2'd1, 1'b0, 8'd1);
    beat(16'h2A05);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_lane", out_lane, 2'd0);
      chk("stall_data", out_data, 24'h000005);
      chk("stall_last", out_last, 1'b0);
      chk("stall_done", done, 1'b0);
      step();
    end
    take("m1_l0", 2'd0, 24'h000005, 1'b0);
    chk("m1_nodone_mid", done, 1'b0);
    take("m1_l1", 2'd1, 24'h00002A, 1'b1);
    expect_done("m1");

    // 4x4 signed
    start_job(2'd2, 1'b1, 8'd1);
    beat(16'hF8A1);
    take("m2_l0", 2'd0, 24'h000001, 1'b0);
    take("m2_l1", 2'd1, 24'hFFFFFA, 1'b0);
    take("m2_l2", 2'd2, 24'hFFFFF8, 1'b0);
    take("m2_l3", 2'd3, 24'hFFFFFF, 1'b1);
    expect_done("m2");

    // 1x16 unsigned carry-out on the 16-bit instance, none on the 24-bit one
    start_job(2'd0, 1'b0, 8'd2);
    beat(16'hFFFF);
    chk("w16_ovf_first", ovf16, 1'b0);
    beat(16'hFFFF);
    chk("w16_data", out_data16, 16'hFFFE);
    chk("w16_ovf", ovf16, 1'b1);
    chk("w16_last", out_last16, 1'b1);
    chk("w24_ovf", ovf, 1'b0);
    take("w24_l0", 2'd0, 24'h01FFFE, 1'b1);
    chk("w16_ovf_sticky", ovf16, 1'b1);
    expect_done("w16");

    // len=0 runs 256 beats; sticky ovf on the 16-bit instance clears at start
    start_job(2'd2, 1'b0, 8'd0);
    chk("len0_ovf_clr", ovf16, 1'b0);
    for (int i = 0; i < 255; i++) beat(16'h1111);
    chk("len0_still_acc", in_ready, 1'b1);
    chk("len0_not_drain", out_valid, 1'b0);
    beat(16'h1111);
    take("len0_l0", 2'd0, 24'h000100, 1'b0);
    take("len0_l1", 2'd1, 24'h000100, 1'b0);
    take("len0_l2", 2'd2, 24'h000100, 1'b0);
    take("len0_l3", 2'd3, 24'h000100, 1'b1);
    chk("len0_ovf16", ovf16, 1'b0);
    expect_done("len0");

    // reset one cycle after the first beat of a len=4 job
    start_job(2'd0, 1'b0, 8'd4);
    beat(16'h0001);
    step();
    reset = 1'b0;
    step();
    chk("mid_busy", busy, 1'b0);
    chk("mid_in_ready", in_ready, 1'b0);
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_out_data", out_data, 24'h0);
    chk("mid_out_lane", out_lane, 2'd0);
    chk("mid_out_last", out_last, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_ovf", ovf, 1'b0);
    reset = 1'b1;
    start_job(2'd1, 1'b1, 8'd1);
    beat(16'h80FF);
    take("post_l0", 2'd0, 24'hFFFFFF, 1'b0);
    take("post_l1", 2'd1, 24'hFFFF80, 1'b1);
    chk("post_ovf", ovf, 1'b0);
    expect_done("post");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_unpack_acc.md
MAC_RESULT_UNPACK_ACC -- requirements
Module: mac_result_unpack_acc

Interface
REQ-001 Parameter: ACC_W, 24, width of each lane accumulator and of out_data (ACC_W >= 16).
REQ-002 Parameter: LEN_W, 8, width of the beat-count field cfg_len.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; reset==0 at a rising edge of clk resets all state.
REQ-005 Port: start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-006 Port: cfg_mode  input  2  packing mode: 0 = one 16-bit product; 1 = two 8-bit products in in_data[7:0] and [15:8]; 2 = four 4-bit products in nibbles [3:0], [7:4], [11:8], [15:12]; 3 = treated as 0.
REQ-007 Port: cfg_signed  input  1  1 = lane products are two's complement; 0 = unsigned.
REQ-008 Port: cfg_len  input  LEN_W  number of input beats per job; 0 means 2^LEN_W.
REQ-009 Port: in_valid  input  1  packed product word valid.
REQ-010 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-011 Port: in_data  input  16  packed product word from the precision-configurable multiplier.
REQ-012 Port: out_valid  output  1  out_data holds a lane result.
REQ-013 Port: out_ready  input  1  downstream accepts out_data.
REQ-014 Port: out_data  output  ACC_W  accumulated lane result.
REQ-015 Port: out_lane  output  2  lane index of out_data.
REQ-016 Port: out_last  output  1  out_data is the final lane of the job.
REQ-017 Port: busy  output  1  high whenever state is not IDLE.
REQ-018 Port: done  output  1  one-cycle pulse after the final lane is transferred.
REQ-019 Port: ovf  output  1  sticky overflow flag for the current or last job.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACC and DRAIN.
REQ-021 In IDLE, start==1 SHALL latch cfg_mode, cfg_signed and cfg_len, clear all four accumulators and ovf, load the beat counter, and enter ACC on the next edge.
REQ-022 start SHALL be ignored outside IDLE; cfg_* changes after latching SHALL have no effect on the running job.
REQ-023 in_ready SHALL be 1 exactly when the state is ACC; a beat is accepted when in_valid && in_ready.
REQ-024 On each accepted beat, every active lane accumulator SHALL add its lane field, zero-extended (unsigned) or sign-extended (signed) to ACC_W; sums wrap modulo 2^ACC_W.
REQ-025 Active lane counts SHALL be 1, 2 and 4 for modes 0, 1 and 2; inactive accumulators SHALL stay 0.
REQ-026 ovf SHALL be set on an unsigned carry-out or a signed two's-complement overflow of any active lane add, and SHALL remain set until the next accepted start.
REQ-027 After the beat that decrements the counter to zero is accepted, the state SHALL be DRAIN on the next cycle, with out_valid=1 and out_lane=0 in that cycle.
REQ-028 In DRAIN, out_data SHALL equal the accumulator at out_lane; out_last=1 SHALL hold when out_lane = active lanes - 1.
REQ-029 out_data, out_lane and out_last SHALL stay stable while out_valid && !out_ready.
REQ-030 On out_valid && out_ready, the block SHALL advance out_lane; on the last lane it SHALL enter IDLE and pulse done for exactly one cycle.
REQ-031 In IDLE and ACC, out_valid, out_last and out_lane SHALL be 0; out_data SHALL be 0 outside DRAIN.

Reset
REQ-032 On reset==0 at a rising edge, including mid-ACC or mid-DRAIN, the FSM SHALL enter IDLE with accumulators, counter, ovf, in_ready, out_valid, out_data, out_lane, out_last, busy and done all 0; the job is discarded.
REQ-033 After reset deasserts, the block SHALL accept start on the first cycle.

Verification
REQ-034 mode=0, signed, len=2, beats 0xFF00 and 0x0100 -> one output: lane 0, data 0x000000, last=1, ovf=0, then a done pulse.
REQ-035 mode=1, unsigned, len=1, beat 0x2A05 -> outputs lane0=0x000005, then lane1=0x00002A with last=1.
REQ-036 mode=2, signed, len=1, beat 0xF8A1 -> lane0=0x000001, lane1=0xFFFFFA, lane2=0xFFFFF8, lane3=0xFFFFFF with last=1.
REQ-037 Drain of REQ-035 with out_ready held low for 3 cycles at lane 0 -> out_valid stays 1 and lane0 data stays stable; 2 transfers total, done follows the last transfer.
REQ-038 ACC_W=16, mode=0, unsigned, len=2, beats 0xFFFF and 0xFFFF -> data 0xFFFE, ovf=1.
REQ-039 reset==0 one cycle after the first beat of a len=4 job -> all outputs 0 the next cycle; a fresh start then completes normally.
